// File: rtl/seq_detect_pkg.sv
// Shared types for the round-robin "010" detector scheduler: state enums, defaults, grant picker.
// No logic state of its own; latency and backpressure belong to the modules that import it.
// rr_pick works on an 8-bit request vector, so callers must zero-extend requests narrower than 8.
package seq_detect_pkg;

    localparam int NREQ_DEF  = 4;
    localparam int WIDTH_DEF = 8;

    typedef enum logic [1:0] {
        S0 = 2'd0,
        S1 = 2'd1,
        S2 = 2'd2,
        S3 = 2'd3
    } det_state_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } ctl_state_t;

    // First set request at or above ptr, wrapping modulo n (n <= 8, ptr < n).
    function automatic logic [2:0] rr_pick(input logic [7:0] req,
                                           input logic [2:0] ptr,
                                           input logic [3:0] n);
        logic [3:0] idx;
        logic       found;
        rr_pick = '0;
        found   = 1'b0;
        for (int k = 0; k < 8; k++) begin
            idx = {1'b0, ptr} + 4'(k);
            if (idx >= n) idx = idx - n;
            if ((4'(k) < n) && !found && req[idx[2:0]]) begin
                rr_pick = idx[2:0];
                found   = 1'b1;
            end
        end
    endfunction

endpackage

// File: rtl/seq_detect_fsm.sv
// Bit-serial Moore detector for "010"; match is decoded from the state register only.
// Latency: one edge per bit, match visible the cycle after the completing bit.
// Backpressure: none; en gates advancement, clr forces S0 and wins over en.
module seq_detect_fsm
    import seq_detect_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    input  logic bit_in,
    output logic match
);

    det_state_t state, state_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S0;
        else        state <= state_nxt;
    end

    // Leaving S3 on a 1 drops all progress, so matches never share a trailing 0 with a 1 after it.
    always_comb begin
        state_nxt = state;
        if (clr) begin
            state_nxt = S0;
        end else if (en) begin
            case (state)
                S0:      state_nxt = bit_in ? S0 : S1;
                S1:      state_nxt = bit_in ? S2 : S1;
                S2:      state_nxt = bit_in ? S0 : S3;
                S3:      state_nxt = bit_in ? S0 : S1;
                default: state_nxt = S0;
            endcase
        end
    end

    assign match = (state == S3);

endmodule

// File: rtl/seq_detect_arbiter.sv
// Round-robin scheduler sharing one serial "010" detector; SEQ_DETECT_ARBITER_ABORT_EN enables aborts.
// Latency: grant after the pick edge, done pulse WIDTH+2 cycles into the grant; one IDLE cycle between frames.
// Backpressure: requesters hold req until their done; new requests are only sampled in IDLE.
module seq_detect_arbiter
    import seq_detect_pkg::*;
#(
    parameter  int NREQ  = NREQ_DEF,
    parameter  int WIDTH = WIDTH_DEF,
    localparam int CW    = $clog2(WIDTH + 1),
    localparam int IW    = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] data_in,
    output logic [NREQ-1:0]       gnt,
    output logic                  done,
    output logic [IW-1:0]         done_id,
    output logic [CW-1:0]         count,
    output logic                  abort
);

    ctl_state_t     state, state_nxt;
    logic [IW-1:0]  ptr;
    logic [IW-1:0]  pick;
    logic [WIDTH-1:0] shreg;
    logic [CW-1:0]  bitcnt;
    logic           match;
    logic           start;
    logic           last_bit;
    logic           abort_now;

    assign pick     = IW'(rr_pick(8'(req), 3'(ptr), 4'(NREQ)));
    assign start    = (state == IDLE) && (|req);
    assign last_bit = (bitcnt == CW'(WIDTH - 1));
    assign done     = (state == DONE);

`ifdef SEQ_DETECT_ARBITER_ABORT_EN
    logic aborted;

    // done_id tracks the granted requester for the whole frame.
    assign abort_now = ((state == SHIFT) || (state == FLUSH)) && !req[done_id];
    assign abort     = done && aborted;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         aborted <= 1'b0;
        else if (start)     aborted <= 1'b0;
        else if (abort_now) aborted <= 1'b1;
    end
`else
    assign abort_now = 1'b0;
    assign abort     = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SHIFT;
            SHIFT: begin
                if (abort_now)     state_nxt = DONE;
                else if (last_bit) state_nxt = FLUSH;
            end
            FLUSH:   state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: count accumulates the match seen before each shift edge, FLUSH adds the last bit's match.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt     <= '0;
            ptr     <= '0;
            done_id <= '0;
            shreg   <= '0;
            bitcnt  <= '0;
            count   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        gnt     <= NREQ'(1) << pick;
                        ptr     <= (pick == IW'(NREQ - 1)) ? '0 : pick + 1'b1;
                        done_id <= pick;
                        shreg   <= data_in[pick*WIDTH +: WIDTH];
                        bitcnt  <= '0;
                        count   <= '0;
                    end
                end
                SHIFT: begin
                    shreg  <= {shreg[WIDTH-2:0], 1'b0};
                    bitcnt <= bitcnt + 1'b1;
                    count  <= count + CW'(match);
                end
                FLUSH: count <= count + CW'(match);
                DONE:  gnt   <= '0;
                default: ;
            endcase
        end
    end

    seq_detect_fsm u_det (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (start),
        .en     (state == SHIFT),
        .bit_in (shreg[WIDTH-1]),
        .match  (match)
    );

endmodule

// File: tb/tb_seq_detect_arbiter.sv
// Directed and randomized frames for seq_detect_arbiter against a word-level reference
// (non-overlapping "010" scan, round-robin pick over a pointer).
module tb_seq_detect_arbiter;

    localparam int NREQ  = 4;
    localparam int WIDTH = 8;
    localparam int CW    = $clog2(WIDTH + 1);
    localparam int IW    = $clog2(NREQ);

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] data_in;
    logic [NREQ-1:0]       gnt;
    logic                  done;
    logic [IW-1:0]         done_id;
    logic [CW-1:0]         count;
    logic                  abort;

    int n_assert = 0;
    int n_fail   = 0;
    int mptr     = 0;
    logic [WIDTH-1:0] words [NREQ];

    always #5 clk = ~clk;

    seq_detect_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .data_in (data_in),
        .gnt     (gnt),
        .done    (done),
        .done_id (done_id),
        .count   (count),
        .abort   (abort)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Non-overlapping "010" occurrences within the first nbits bits, MSB first.
    function automatic int ref_count(input logic [WIDTH-1:0] w, input int nbits);
        int c = 0;
        int k = 0;
        while (k + 2 < nbits) begin
            if (!w[WIDTH-1-k] && w[WIDTH-2-k] && !w[WIDTH-3-k]) begin
                c++;
                k += 3;
            end else begin
                k++;
            end
        end
        return c;
    endfunction

    function automatic int rr_expect(input logic [NREQ-1:0] r);
        for (int k = 0; k < NREQ; k++)
            if (r[(mptr + k) % NREQ]) return (mptr + k) % NREQ;
        return -1;
    endfunction

    task automatic pack_words();
        for (int i = 0; i < NREQ; i++) data_in[i*WIDTH +: WIDTH] = words[i];
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_gnt"},     32'(gnt),     0);
        check({tag, "_done"},    32'(done),    0);
        check({tag, "_done_id"}, 32'(done_id), 0);
        check({tag, "_count"},   32'(count),   0);
        check({tag, "_abort"},   32'(abort),   0);
    endtask

    // Waits for a grant, returns after checking it at SHIFT cycle 1 (the first negedge with gnt).
    task automatic wait_grant(output int waited, output int e);
        e = rr_expect(req);
        if (e < 0) e = 0;
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (gnt == '0 && waited < 40);
        check("grant_seen", 32'(gnt != '0), 1);
        check("gnt_rr", 32'(gnt), 32'(1) << e);
        mptr = (e + 1) % NREQ;
    endtask

    // Full frame: grant, WIDTH+2 grant cycles, done on the last with id/count; returns at the done negedge.
    task automatic serve(output int waited, output int e);
        int exp_cnt;
        wait_grant(waited, e);
        exp_cnt = ref_count(words[e], WIDTH);
        for (int c = 2; c <= WIDTH + 1; c++) begin
            @(negedge clk);
            check("gnt_hold", 32'(gnt), 32'(1) << e);
            check("done_low", 32'(done), 0);
        end
        @(negedge clk);
        check("done_pulse", 32'(done), 1);
        check("gnt_in_done", 32'(gnt), 32'(1) << e);
        check("done_id", 32'(done_id), 32'(e));
        check("count", 32'(count), 32'(exp_cnt));
        check("abort_low", 32'(abort), 0);
    endtask

    initial begin
        int waited, id;
        rst_n   = 1'b0;
        req     = '0;
        data_in = '0;
        for (int i = 0; i < NREQ; i++) words[i] = '0;
        @(negedge clk);
        @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;

        // Two-match word, granted one cycle after the request
        words[0] = 8'b0100_1010;
        pack_words();
        req = 4'b0001;
        serve(waited, id);
        check("first_latency", 32'(waited), 1);
        req = '0;
        @(negedge clk);
        check("idle_after_done_gnt", 32'(gnt), 0);
        check("idle_after_done_done", 32'(done), 0);

        // Match completed by the last bit
        words[0] = 8'b0000_0010;
        pack_words();
        req = 4'b0001;
        serve(waited, id);

        // Zero matches, then two, back to back: count must restart
        words[0] = 8'hFF;
        pack_words();
        serve(waited, id);
        words[0] = 8'b0101_0101;
        pack_words();
        serve(waited, id);
        check("b2b_spacing", 32'(waited), 2);

        // All requesting: rotation with one IDLE cycle between frames
        words[0] = 8'h4A; words[1] = 8'h02; words[2] = 8'h55; words[3] = 8'h92;
        pack_words();
        req = 4'b1111;
        for (int f = 0; f < 5; f++) begin
            serve(waited, id);
            check("rot_spacing", 32'(waited), 2);
        end
        req = '0;
        @(negedge clk);

        // Reset in SHIFT cycle 4 kills the frame; next grant from pointer 0
        words[0] = 8'h4A;
        pack_words();
        req = 4'b0001;
        wait_grant(waited, id);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_all_zero("midreset");
        req = 4'b0100;
        @(negedge clk);
        @(negedge clk);
        check_all_zero("hold_reset");
        mptr  = 0;
        rst_n = 1'b1;
        serve(waited, id);
        check("post_reset_id", 32'(id), 2);
        req = '0;
        @(negedge clk);

        // Requester 0 drops req during SHIFT cycle 3
        words[0] = 8'b0100_1010;
        pack_words();
        req = 4'b0001;
        wait_grant(waited, id);
        @(negedge clk);
        @(negedge clk);
        req = '0;
`ifdef SEQ_DETECT_ARBITER_ABORT_EN
        @(negedge clk);
        check("abort_done", 32'(done), 1);
        check("abort_flag", 32'(abort), 1);
        check("abort_id", 32'(done_id), 0);
        check("abort_count", 32'(count), 32'(ref_count(words[0], 2)));
`else
        for (int c = 4; c <= WIDTH + 1; c++) begin
            @(negedge clk);
            check("noabort_done_low", 32'(done), 0);
        end
        @(negedge clk);
        check("noabort_done", 32'(done), 1);
        check("noabort_flag", 32'(abort), 0);
        check("noabort_count", 32'(count), 2);
`endif
        @(negedge clk);
        check("abort_gnt_clear", 32'(gnt), 0);

        // Random traffic: served requesters keep or drop req at their done
        for (int f = 0; f < 40; f++) begin
            for (int i = 0; i < NREQ; i++) words[i] = WIDTH'($urandom);
            pack_words();
            req = req | NREQ'($urandom_range(0, (1 << NREQ) - 1));
            if (req == '0) req[$urandom_range(0, NREQ - 1)] = 1'b1;
            serve(waited, id);
            if ($urandom_range(0, 1) == 1) req[id] = 1'b0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
